// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared defaults, x0 constant and register-address type for the register file slice
package regfile_scoreboard_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO = 0;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard_counter.sv
// regfile_scoreboard_counter: per-register pending-write up/down counter; ports clk, reset, inc_req, wr_hit -> stall, nonzero, busy
module regfile_scoreboard_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_req,
  input  logic wr_hit,
  output logic stall,
  output logic nonzero,
  output logic busy
);
  logic [CNT_W-1:0] cnt;
  logic dec, inc;
  always_comb begin
    dec = wr_hit && cnt != '0;
    stall = inc_req && (&cnt) && !wr_hit;
    inc = inc_req && !stall;
    nonzero = cnt != '0;
    busy = cnt != CNT_W'(dec);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= cnt + CNT_W'(inc) - CNT_W'(dec);
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREAD-port register file with write bypass, hardwired x0 and per-register pending-write scoreboard; ports clk, reset, rd_addr/rd_data/rd_busy, wr_en/wr_addr/wr_data, alloc_en/alloc_addr/alloc_stall, pending_any
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int CNT_W = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  output logic                  alloc_stall,
  output logic                  pending_any
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] stall_v, nz_v, busy_v;
  logic wr_ok;
  assign wr_ok = wr_en && wr_addr != AW'(REG_ZERO);
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wr_ok) regs[wr_addr] <= wr_data;
  assign stall_v[0] = 1'b0;
  assign nz_v[0] = 1'b0;
  assign busy_v[0] = 1'b0;
  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    regfile_scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_req (alloc_en && alloc_addr == AW'(i)),
      .wr_hit  (wr_en && wr_addr == AW'(i)),
      .stall   (stall_v[i]),
      .nonzero (nz_v[i]),
      .busy    (busy_v[i])
    );
  end
  assign alloc_stall = |stall_v;
  assign pending_any = |nz_v;
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_data[p*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0 : (wr_en && wr_addr == a) ? wr_data : regs[a];
    assign rd_busy[p] = busy_v[a];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;
  localparam int XL = 64;
  localparam int NR = 4;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic reset;
  logic [NR*5-1:0] rd_addr;
  logic [NR*XL-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic wr_en, alloc_en, alloc_stall, pending_any;
  reg_addr_t wr_addr, alloc_addr;
  logic [XL-1:0] wr_data;
  reg_addr_t ra [NR];
  logic [XL-1:0] mem [32];
  int cnt [32];
  int checks = 0;
  int errors = 0;
  regfile_scoreboard #(.XLEN(XL), .NREGS(32), .NREAD(NR), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .alloc_stall(alloc_stall), .pending_any(pending_any)
  );
  always #5 clk = ~clk;
  assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};
  task automatic chk(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [XL-1:0] exp_rd(input reg_addr_t a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction
  function automatic logic exp_busy(input reg_addr_t a);
    int c;
    c = cnt[a];
    if (wr_en && wr_addr == a && c > 0) c--;
    return a != 0 && c > 0;
  endfunction
  function automatic logic exp_stall();
    return alloc_en && alloc_addr != 0 && cnt[alloc_addr] == MAXC && !(wr_en && wr_addr == alloc_addr);
  endfunction
  function automatic logic exp_pending();
    for (int i = 0; i < 32; i++) if (cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      cnt[i] = 0;
    end
  endtask
  task automatic check_outputs();
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rd_data%0d x%0d", p, ra[p]), rd_data[p*XL +: XL], exp_rd(ra[p]));
      chk($sformatf("rd_busy%0d x%0d", p, ra[p]), {63'd0, rd_busy[p]}, {63'd0, exp_busy(ra[p])});
    end
    chk("alloc_stall", {63'd0, alloc_stall}, {63'd0, exp_stall()});
    chk("pending_any", {63'd0, pending_any}, {63'd0, exp_pending()});
  endtask
  task automatic tick();
    logic s, d, i;
    #1 check_outputs();
    @(posedge clk);
    s = exp_stall();
    d = wr_en && wr_addr != 0 && cnt[wr_addr] > 0;
    i = alloc_en && alloc_addr != 0 && !s;
    if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
    if (d) cnt[wr_addr]--;
    if (i) cnt[alloc_addr]++;
    @(negedge clk);
  endtask
  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = '0; alloc_en = 0; alloc_addr = 0;
  endtask
  task automatic wr(input reg_addr_t a, input logic [XL-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask
  task automatic al(input reg_addr_t a);
    alloc_en = 1; alloc_addr = a;
  endtask
  initial begin
    reset = 1;
    idle();
    for (int p = 0; p < NR; p++) ra[p] = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NR; p++) ra[p] = reg_addr_t'(4 * k + p);
      #1 chk("reset_pending", {63'd0, pending_any}, 64'd0);
      chk("reset_busy", {60'd0, rd_busy}, 64'd0);
      chk("reset_data", rd_data[XL-1:0] | rd_data[2*XL-1:XL], 64'd0);
      tick();
    end
    ra[0] = 5;
    wr(5, 64'hDEADBEEF);
    #1 chk("bypass_x5", rd_data[XL-1:0], 64'hDEADBEEF);
    tick();
    idle();
    #1 chk("array_x5", rd_data[XL-1:0], 64'hDEADBEEF);
    tick();
    ra[0] = 0;
    wr(0, 64'h1234);
    #1 chk("x0_bypass", rd_data[XL-1:0], 64'd0);
    tick();
    idle();
    #1 chk("x0_array", rd_data[XL-1:0], 64'd0);
    tick();
    ra[0] = 7;
    al(7);
    repeat (3) tick();
    idle();
    #1 chk("x7_busy", {63'd0, rd_busy[0]}, 64'd1);
    tick();
    al(7);
    #1 chk("x7_stall", {63'd0, alloc_stall}, 64'd1);
    tick();
    #1 chk("x7_stall_held", {63'd0, alloc_stall}, 64'd1);
    wr(7, 64'h77);
    #1 chk("x7_alloc_wr_ok", {63'd0, alloc_stall}, 64'd0);
    tick();
    idle();
    al(7);
    #1 chk("x7_still_full", {63'd0, alloc_stall}, 64'd1);
    idle();
    wr(7, 64'h70);
    repeat (3) tick();
    idle();
    #1 chk("x7_drained", {63'd0, rd_busy[0]}, 64'd0);
    chk("drained_pending", {63'd0, pending_any}, 64'd0);
    tick();
    ra[0] = 9;
    al(9);
    tick();
    wr(9, 64'h99);
    tick();
    idle();
    #1 chk("x9_cnt1_busy", {63'd0, rd_busy[0]}, 64'd1);
    wr(9, 64'h9A);
    tick();
    idle();
    #1 chk("x9_cnt0_busy", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    ra[0] = 3;
    wr(3, 64'h3333);
    al(3);
    tick();
    idle();
    al(3);
    tick();
    idle();
    #2 reset = 1;
    #1 chk("rst_data", rd_data[XL-1:0], 64'd0);
    chk("rst_busy", {63'd0, rd_busy[0]}, 64'd0);
    chk("rst_pending", {63'd0, pending_any}, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 0;
    #1 chk("post_rst_x3", rd_data[XL-1:0], 64'd0);
    chk("post_rst_busy", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    for (int r = 1; r <= 4; r++) begin
      wr(reg_addr_t'(r), 64'h1000 + 64'(r));
      tick();
    end
    for (int p = 0; p < NR; p++) ra[p] = reg_addr_t'(p + 1);
    wr(2, 64'hCAFE_F00D_0000_0002);
    #1 chk("p0_x1", rd_data[XL-1:0], 64'h1001);
    chk("p1_x2_bypass", rd_data[2*XL-1:XL], 64'hCAFE_F00D_0000_0002);
    chk("p2_x3", rd_data[3*XL-1:2*XL], 64'h1003);
    chk("p3_x4", rd_data[4*XL-1:3*XL], 64'h1004);
    tick();
    for (int n = 0; n < 10000; n++) begin
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = reg_addr_t'($urandom_range(0, 7));
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = reg_addr_t'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom};
      for (int p = 0; p < NR; p++)
        ra[p] = reg_addr_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
